io_uart_tx: RTL and testbench

- Synthesizable UART transmitter that sits on the CPU I/O bus (active-low CS/WE/OE, 16-bit address, 8-bit data).
- CPU writes to the data port at 0x0800 push a byte into a small TX FIFO. A serializer drains the FIFO onto the serial line as 8N1 frames.
- The status port at 0x0A00 returns a busy flag. The CPU polls it before each write.

---
 rtl/io_uart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
//------------------------------------------------------------------------------
// Module  : io_uart_tx
// Brief   : CPU-bus UART transmitter: small TX FIFO drained by an 8N1 serializer.
//           Define UART_TX_PARITY_EN to insert an even parity bit (8E1 framing).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_uart_tx #(
    parameter int          DIVISOR     = 434,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DATA_ADDR   = 16'h0800,
    parameter logic [15:0] STATUS_ADDR = 16'h0A00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Address,
    input  logic [7:0]  DataIn,
    output logic [7:0]  DataOut,
    output logic        DataOE,
    input  logic        nCS,
    input  logic        nWE,
    input  logic        nOE,
    output logic        txd,
    output logic        tx_active
);

    localparam int                 c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w     = $clog2(DIVISOR);
    localparam logic [c_cnt_w-1:0] c_baud_load = c_cnt_w'(DIVISOR - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    // Bus strobe synchronizer, bit order {nOE, nWE, nCS}
    logic [2:0] r_bus_s1;
    logic [2:0] r_bus_s2;
    logic       r_wr_prev;
    logic       r_rd_prev;
    logic       w_wr_n;
    logic       w_rd_n;
    logic       w_wr_evt;
    logic       w_rd_evt;

    assign w_wr_n   = r_bus_s2[0] | r_bus_s2[1];
    assign w_rd_n   = r_bus_s2[0] | r_bus_s2[2];
    assign w_wr_evt = r_wr_prev & ~w_wr_n;
    assign w_rd_evt = r_rd_prev & ~w_rd_n & (Address == STATUS_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_s1  <= 3'b111;
            r_bus_s2  <= 3'b111;
            r_wr_prev <= 1'b1;
            r_rd_prev <= 1'b1;
        end else begin
            r_bus_s1  <= {nOE, nWE, nCS};
            r_bus_s2  <= r_bus_s1;
            r_wr_prev <= w_wr_n;
            r_rd_prev <= w_rd_n;
        end
    end

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0] r_wptr;
    logic [c_ptr_w:0] r_rptr;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_data_wr;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [7:0]       w_rd_data;

    assign w_full    = (r_wptr ^ r_rptr) == {1'b1, {c_ptr_w{1'b0}}};
    assign w_empty   = (r_wptr == r_rptr);
    assign w_data_wr = w_wr_evt & (Address == DATA_ADDR);
    assign w_push    = w_data_wr & (~w_full | w_pop);
    assign w_drop    = w_data_wr & w_full & ~w_pop;
    assign w_rd_data = r_mem[r_rptr[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= DataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_rd_evt) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer; txd and tx_active are registered one clk behind the state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_baud;
    logic [c_cnt_w-1:0] w_baud_nxt;
    logic [2:0]         r_bitcnt;
    logic [2:0]         w_bitcnt_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_txd;
    logic               w_txd_nxt;
    logic               r_active;
    logic               w_baud_done;

    assign w_baud_done = (r_baud == '0);

`ifdef UART_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= ^w_rd_data;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        w_txd_nxt    = 1'b1;

        if (r_state != S_IDLE) begin
            w_baud_nxt = w_baud_done ? c_baud_load : (r_baud - 1'b1);
        end

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_rd_data;
                    w_baud_nxt   = c_baud_load;
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                w_txd_nxt = 1'b0;
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd_nxt = r_shift[0];
                if (w_baud_done) begin
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_txd_nxt = r_par;
                if (w_baud_done) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt = S_IDLE;
                    w_baud_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_txd    <= 1'b1;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_txd    <= w_txd_nxt;
            r_active <= (r_state != S_IDLE);
        end
    end

    // Status read path is combinational off the raw bus to meet async read timing
    assign DataOE    = ~reset & ~nCS & ~nOE & (Address == STATUS_ADDR);
    assign DataOut   = DataOE ? {4'b0000, r_ovf, w_empty, r_active, w_full} : 8'h00;
    assign txd       = r_txd;
    assign tx_active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_io_uart_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_io_uart_tx
// Brief   : Self-checking bench for io_uart_tx; decodes the serial line into
//           frames and compares against a queue model of accepted bytes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_io_uart_tx;

    localparam int          DIV    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] A_DATA = 16'h0800;
    localparam logic [15:0] A_STAT = 16'h0A00;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Address;
    logic [7:0]  DataIn;
    logic [7:0]  DataOut;
    logic        DataOE;
    logic        nCS;
    logic        nWE;
    logic        nOE;
    logic        txd;
    logic        tx_active;

    io_uart_tx #(
        .DIVISOR    (DIV),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (A_DATA),
        .STATUS_ADDR(A_STAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .DataOE   (DataOE),
        .nCS      (nCS),
        .nWE      (nWE),
        .nOE      (nOE),
        .txd      (txd),
        .tx_active(tx_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic        herr;
        logic [31:0] start;
    } frame_t;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         n_accepted = 0;
    int         n_started  = 0;
    bit         exp_ovf    = 1'b0;
    logic [7:0] exp_q[$];
    frame_t     rx_q[$];
    int         act_q[$];

    // Line monitor: decodes frames from txd levels, one sample per clk
    bit               mbusy = 1'b0;
    int               mpos  = 0;
    int               arun  = 0;
    logic [NBITS-1:0] mbits;
    logic             mherr;
    int               mstart;
    frame_t           mf;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            mbusy = 1'b0;
            arun  = 0;
        end else begin
            if (tx_active === 1'b1) begin
                arun++;
            end else if (arun != 0) begin
                act_q.push_back(arun);
                arun = 0;
            end
            if (!mbusy && txd === 1'b0) begin
                mbusy  = 1'b1;
                mpos   = 0;
                mherr  = 1'b0;
                mstart = cyc;
                mbits  = '0;
                n_started++;
            end
            if (mbusy) begin
                if (mpos % DIV == 0) mbits[mpos/DIV] = txd;
                else if (txd !== mbits[mpos/DIV]) mherr = 1'b1;
                mpos++;
                if (mpos == NBITS*DIV) begin
                    mf.data  = mbits[8:1];
                    mf.par   = mbits[NBITS-2];
                    mf.stop  = mbits[NBITS-1];
                    mf.herr  = mherr;
                    mf.start = mstart;
                    rx_q.push_back(mf);
                    mbusy = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] model_status();
        return {4'b0000, exp_ovf, (n_accepted == n_started), mbusy,
                ((n_accepted - n_started) == DEPTH)};
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        if (a == A_DATA) begin
            if (n_accepted - n_started < DEPTH) begin
                exp_q.push_back(d);
                n_accepted++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1 Address = a; DataIn = d; nCS = 1'b0; nWE = 1'b0;
        repeat (2) @(posedge clk);
        #1 nCS = 1'b1; nWE = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic read_port(input logic [15:0] a, output logic oe, output logic [7:0] v);
        @(posedge clk);
        #1 Address = a; nCS = 1'b0; nOE = 1'b0;
        #1 oe = DataOE; v = DataOut;
        repeat (2) @(posedge clk);
        #1 nCS = 1'b1; nOE = 1'b1;
        repeat (3) @(posedge clk);
        if (a == A_STAT) exp_ovf = 1'b0;
    endtask

    task automatic get_frame(output frame_t f, output int run, output bit ok);
        int t = 0;
        while ((rx_q.size() == 0 || act_q.size() == 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        ok = (rx_q.size() != 0 && act_q.size() != 0);
        f = '0;
        run = 0;
        if (ok) begin
            f   = rx_q.pop_front();
            run = act_q.pop_front();
        end
    endtask

    task automatic test_reset();
        logic       oe;
        logic [7:0] v;
        reset = 1'b1;
        nCS = 1'b1; nWE = 1'b1; nOE = 1'b1; Address = 16'h0; DataIn = 8'h0;
        #3 Address = A_STAT; nCS = 1'b0; nOE = 1'b0;
        #1;
        n_checks++; if (DataOE !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", DataOE); end
        n_checks++; if (DataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", DataOut); end
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_checks++; if (tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", tx_active); end
        repeat (3) @(posedge clk);
        #1 nCS = 1'b1; nOE = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        read_port(A_STAT, oe, v);
        n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL reset_status: got %h expected 04", v); end
    endtask

    task automatic test_single_frame();
        frame_t f;
        int     run;
        bit     ok;
        exp_q.push_back(8'h55);
        n_accepted++;
        @(posedge clk);
        #1 Address = A_DATA; DataIn = 8'h55; nCS = 1'b0; nWE = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL latency_early: txd %b at 4 clk, expected 1", txd); end
        @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL latency: txd %b at 5 clk, expected 0", txd); end
        nCS = 1'b1; nWE = 1'b1;
        get_frame(f, run, ok);
        n_checks++; if (!ok || f.data !== exp_q.pop_front()) begin n_fail++; $display("FAIL single_data: got %h ok=%0d expected 55", f.data, ok); end
        n_checks++; if (f.herr !== 1'b0 || f.stop !== 1'b1) begin n_fail++; $display("FAIL single_shape: herr=%b stop=%b expected 0/1", f.herr, f.stop); end
        n_checks++; if (run !== NBITS*DIV) begin n_fail++; $display("FAIL single_active: got %0d clk expected %0d", run, NBITS*DIV); end
        @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_idle_txd: got %b expected 1", txd); end
    endtask

    task automatic test_back_to_back();
        frame_t     f;
        int         run;
        bit         ok;
        int         prev_start;
        logic       oe;
        logic [7:0] v;
        logic [7:0] e;
        for (int i = 1; i <= 5; i++) do_write(A_DATA, 8'(i));
        read_port(A_STAT, oe, v);
        n_checks++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", v[0]); end
        n_checks++; if (v !== model_status()) begin n_fail++; $display("FAIL b2b_status: got %h expected %h", v, model_status()); end
        prev_start = 0;
        for (int i = 0; i < 5; i++) begin
            get_frame(f, run, ok);
            e = exp_q.pop_front();
            n_checks++; if (!ok || f.data !== e || f.herr !== 1'b0 || f.stop !== 1'b1) begin
                n_fail++; $display("FAIL b2b_frame[%0d]: got %h ok=%0d herr=%b stop=%b expected %h", i, f.data, ok, f.herr, f.stop, e);
            end
            n_checks++; if (run !== NBITS*DIV) begin n_fail++; $display("FAIL b2b_active[%0d]: got %0d expected %0d", i, run, NBITS*DIV); end
            if (i > 0) begin
                n_checks++; if (int'(f.start) - prev_start !== NBITS*DIV + 1) begin
                    n_fail++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, int'(f.start) - prev_start, NBITS*DIV + 1);
                end
            end
            prev_start = int'(f.start);
        end
    endtask

    task automatic test_overflow();
        frame_t     f;
        int         run;
        bit         ok;
        logic       oe;
        logic [7:0] v;
        logic [7:0] e;
        for (int i = 0; i < 6; i++) do_write(A_DATA, 8'($urandom));
        e = model_status();
        read_port(A_STAT, oe, v);
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL ovf_status: got %h expected %h", v, e); end
        n_checks++; if (v[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_bit: got %b expected 1", v[3]); end
        e = model_status();
        read_port(A_STAT, oe, v);
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", v, e); end
        for (int i = 0; i < 5; i++) begin
            get_frame(f, run, ok);
            e = exp_q.pop_front();
            n_checks++; if (!ok || f.data !== e) begin n_fail++; $display("FAIL ovf_frame[%0d]: got %h ok=%0d expected %h", i, f.data, ok, e); end
        end
        repeat (60) @(posedge clk);
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL ovf_extra_frames: got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_status_port();
        logic       oe;
        logic [7:0] v;
        read_port(A_STAT, oe, v);
        n_checks++; if (oe !== 1'b1 || v !== 8'h04) begin n_fail++; $display("FAIL status_idle: oe=%b dout=%h expected 1/04", oe, v); end
        read_port(A_DATA, oe, v);
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL status_wrong_addr: oe=%b expected 0", oe); end
    endtask

    task automatic test_random();
        frame_t     f;
        int         run;
        bit         ok;
        int         n;
        logic [7:0] e;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) do_write(16'h0801, 8'($urandom));
                do_write(A_DATA, 8'($urandom));
                repeat ($urandom_range(0, 15)) @(posedge clk);
            end
            while (exp_q.size() != 0) begin
                get_frame(f, run, ok);
                e = exp_q.pop_front();
                n_checks++; if (!ok || f.data !== e || f.herr !== 1'b0 || f.stop !== 1'b1) begin
                    n_fail++; $display("FAIL rand_frame[%0d]: got %h ok=%0d herr=%b stop=%b expected %h", r, f.data, ok, f.herr, f.stop, e);
                end
            end
        end
        repeat (60) @(posedge clk);
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rand_extra_frames: got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        logic       oe;
        logic [7:0] v;
        int         t = 0;
        do_write(A_DATA, 8'($urandom) & 8'hF7);
        do_write(A_DATA, 8'($urandom));
        while (!(mbusy && mpos >= 4*DIV + 2) && t < 500) begin
            @(negedge clk);
            #1 t++;
        end
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: txd %b expected 0 (t=%0d)", txd, t); end
        reset = 1'b1;
        #1;
        n_checks++; if (txd !== 1'b1 || tx_active !== 1'b0) begin n_fail++; $display("FAIL mid_abort: txd=%b active=%b expected 1/0", txd, tx_active); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        act_q.delete();
        n_accepted = n_started;
        exp_ovf = 1'b0;
        read_port(A_STAT, oe, v);
        n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL mid_status: got %h expected 04", v); end
        repeat (60) @(posedge clk);
        n_checks++; if (rx_q.size() !== 0 || txd !== 1'b1) begin n_fail++; $display("FAIL mid_fifo_flushed: frames=%0d txd=%b expected 0/1", rx_q.size(), txd); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        frame_t f;
        int     run;
        bit     ok;
        logic [7:0] e;
        do_write(A_DATA, 8'h07);
        get_frame(f, run, ok);
        e = exp_q.pop_front();
        n_checks++; if (!ok || f.data !== e) begin n_fail++; $display("FAIL par_data: got %h ok=%0d expected %h", f.data, ok, e); end
        n_checks++; if (f.par !== 1'b1) begin n_fail++; $display("FAIL par_bit: got %b expected 1", f.par); end
        n_checks++; if (run !== 44) begin n_fail++; $display("FAIL par_len: got %0d expected 44", run); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_status_port();
        test_random();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
